// File: rtl/bp_pkg.sv
// bp_pkg: shared types and saturating-counter helpers for nbit_branch_predictor.
package bp_pkg;
  typedef enum logic {BP_INIT, BP_RUN} bp_state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] tag;
    logic [3:0]  cnt;
    logic [31:0] target;
  } bp_entry_t;
  function automatic logic [3:0] sat_inc(input logic [3:0] c, input int w);
    return (c == 4'((1 << w) - 1)) ? c : c + 4'd1;
  endfunction
  function automatic logic [3:0] sat_dec(input logic [3:0] c);
    return (c == 4'd0) ? c : c - 4'd1;
  endfunction
endpackage

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next value of a CNT_W-bit saturating counter given the resolved direction.
module bp_sat_counter import bp_pkg::*; #(
  parameter int CNT_W = 2
) (
  input  logic [3:0] cnt,
  input  logic       taken,
  output logic [3:0] nxt
);
  assign nxt = taken ? sat_inc(cnt, CNT_W) : sat_dec(cnt);
endmodule

// File: rtl/nbit_branch_predictor.sv
// nbit_branch_predictor: direct-mapped counter+BTB predictor with init FSM.
// Define GSHARE_EN to XOR a non-speculative global history into both index paths.
module nbit_branch_predictor import bp_pkg::*; #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_if_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  output logic        o_pred_hit,
  output logic        o_ready,
  input  logic        i_ex_vld,
  input  logic        i_ex_is_br,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_target,
  output logic        o_ex_mispredict
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int WNT = (1 << (CNT_W - 1)) - 1;
  localparam logic [31:0] TAG_M = 32'((64'd1 << TAG_W) - 1);
  bp_state_e state;
  logic [IDX_W-1:0] idx_cnt, hx, l_idx, u_idx, w_idx;
  logic [31:0] l_tag, u_tag;
  bp_entry_t tbl [ENTRIES];
  bp_entry_t le, ue, w_e;
  logic [3:0] u_nxt;
  logic run, init, l_hit, u_hit, upd, w_en;
  assign run = state == BP_RUN;
  assign init = state == BP_INIT;
`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr;
  assign hx = IDX_W'(ghr);
  always_ff @(posedge i_clk)
    if (i_rst) ghr <= '0;
    else if (upd) ghr <= {ghr[GHR_W-2:0], i_ex_taken};
`else
  assign hx = '0;
`endif
  assign l_idx = IDX_W'(i_if_pc >> 2) ^ hx;
  assign u_idx = IDX_W'(i_ex_pc >> 2) ^ hx;
  assign l_tag = (i_if_pc >> (IDX_W + 2)) & TAG_M;
  assign u_tag = (i_ex_pc >> (IDX_W + 2)) & TAG_M;
  assign le = tbl[l_idx];
  assign ue = tbl[u_idx];
  assign l_hit = run && le.valid && le.tag == l_tag;
  assign u_hit = ue.valid && ue.tag == u_tag;
  assign upd = run && i_ex_vld && i_ex_is_br;
  assign o_ready = run;
  assign o_pred_hit = l_hit;
  assign o_pred_taken = l_hit && le.cnt >= 4'(WNT + 1);
  assign o_pred_target = o_pred_taken ? le.target : i_if_pc + 32'd4;
  assign o_ex_mispredict = upd && (i_ex_taken != i_ex_pred_taken ||
                           (i_ex_taken && i_ex_pred_taken && i_ex_target != i_ex_pred_target));
  bp_sat_counter #(.CNT_W(CNT_W)) u_cnt (.cnt(ue.cnt), .taken(i_ex_taken), .nxt(u_nxt));
  assign w_en = init || (upd && (i_ex_taken || u_hit));
  assign w_idx = init ? idx_cnt : u_idx;
  // A taken miss replaces the entry and starts it weakly taken.
  always_comb begin
    w_e = ue;
    w_e.cnt = u_nxt;
    if (i_ex_taken) begin
      w_e.valid = 1'b1;
      w_e.tag = u_tag;
      w_e.target = i_ex_target;
      w_e.cnt = u_hit ? u_nxt : 4'(WNT + 1);
    end
    if (init) begin
      w_e = '0;
      w_e.cnt = 4'(WNT);
    end
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      state <= BP_INIT;
      idx_cnt <= '0;
    end else begin
      if (w_en) tbl[w_idx] <= w_e;
      if (init) begin
        idx_cnt <= idx_cnt + 1'b1;
        if (idx_cnt == IDX_W'(ENTRIES - 1)) state <= BP_RUN;
      end
    end
endmodule

// File: tb/tb_nbit_branch_predictor.sv
// tb_nbit_branch_predictor: directed and random checks against a table-level reference model.
module tb_nbit_branch_predictor;
  logic        i_clk = 0, i_rst, i_ex_vld, i_ex_is_br, i_ex_taken, i_ex_pred_taken;
  logic [31:0] i_if_pc, i_ex_pc, i_ex_target, i_ex_pred_target;
  logic        o_pred_taken, o_pred_hit, o_ready, o_ex_mispredict;
  logic [31:0] o_pred_target;
  int nassert = 0, nfail = 0;
  bit mv [64];
  int mt [64], mc [64];
  logic [31:0] mtg [64];
  bit rdy = 0;
  int icnt = 0;

  nbit_branch_predictor dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_if_pc(i_if_pc), .o_pred_taken(o_pred_taken),
    .o_pred_target(o_pred_target), .o_pred_hit(o_pred_hit), .o_ready(o_ready),
    .i_ex_vld(i_ex_vld), .i_ex_is_br(i_ex_is_br), .i_ex_pc(i_ex_pc), .i_ex_taken(i_ex_taken),
    .i_ex_target(i_ex_target), .i_ex_pred_taken(i_ex_pred_taken),
    .i_ex_pred_target(i_ex_pred_target), .o_ex_mispredict(o_ex_mispredict));

  always #5 i_clk = ~i_clk;

  function automatic int midx(input logic [31:0] pc); return int'((pc >> 2) % 64); endfunction
  function automatic int mtag(input logic [31:0] pc); return int'((pc >> 8) % 256); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_ex_vld = 0; i_ex_is_br = 0; i_ex_pc = 0; i_ex_taken = 0;
    i_ex_target = 0; i_ex_pred_taken = 0; i_ex_pred_target = 0;
  endtask

  task automatic br(input logic [31:0] pc, input bit tk, input logic [31:0] tg,
                    input bit ptk, input logic [31:0] ptg);
    i_ex_vld = 1; i_ex_is_br = 1; i_ex_pc = pc; i_ex_taken = tk;
    i_ex_target = tg; i_ex_pred_taken = ptk; i_ex_pred_target = ptg;
  endtask

  // Compare every output against the model, then clock once and advance the model.
  task automatic step();
    int i, t;
    bit eh, et, em;
    #2;
    i = midx(i_if_pc);
    eh = rdy && mv[i] && mt[i] == mtag(i_if_pc);
    et = eh && mc[i] >= 2;
    em = rdy && i_ex_vld && i_ex_is_br && (i_ex_taken != i_ex_pred_taken ||
         (i_ex_taken && i_ex_pred_taken && i_ex_target != i_ex_pred_target));
    chk("ready", 32'(o_ready), 32'(rdy));
    chk("hit", 32'(o_pred_hit), 32'(eh));
    chk("taken", 32'(o_pred_taken), 32'(et));
    chk("target", o_pred_target, et ? mtg[i] : i_if_pc + 4);
    chk("mispredict", 32'(o_ex_mispredict), 32'(em));
    @(posedge i_clk);
    if (i_rst) begin
      rdy = 0; icnt = 0;
    end else if (!rdy) begin
      icnt++;
      if (icnt == 64) begin
        rdy = 1;
        for (int k = 0; k < 64; k++) begin mv[k] = 0; mt[k] = 0; mc[k] = 1; mtg[k] = 0; end
      end
    end else if (i_ex_vld && i_ex_is_br) begin
      i = midx(i_ex_pc); t = mtag(i_ex_pc);
      eh = mv[i] && mt[i] == t;
      if (i_ex_taken) begin
        mc[i] = eh ? (mc[i] == 3 ? 3 : mc[i] + 1) : 2;
        mv[i] = 1; mt[i] = t; mtg[i] = i_ex_target;
      end else if (eh) mc[i] = mc[i] == 0 ? 0 : mc[i] - 1;
    end
    @(negedge i_clk);
  endtask

  task automatic count_init(input string tag);
    int n = 0;
    while (!o_ready && n < 200) begin
      i_if_pc = $urandom & 32'hfffc;
      step();
      n++;
    end
    chk(tag, n, 64);
  endtask

  task automatic look(input logic [31:0] pc);
    idle(); i_if_pc = pc; step();
  endtask

  initial begin
    i_rst = 1; i_if_pc = 32'h100; idle();
    @(negedge i_clk); @(posedge i_clk); @(negedge i_clk);
    step();
    i_rst = 0;
    count_init("t1_init_len");
    // Restart INIT at cycle 30 with a taken update pending throughout.
    i_rst = 1; step(); i_rst = 0;
    for (int k = 0; k < 29; k++) step();
    i_rst = 1; step(); i_rst = 0;
    br(32'h100, 1, 32'h80, 0, 0);
    count_init("t2_init_len");
    look(32'h100);
    chk("t2_no_write", 32'(o_pred_hit), 0);
    // Training sequence on 0x100.
    br(32'h100, 1, 32'h80, 0, 0); step();
    look(32'h100);
    chk("t3_hit", 32'(o_pred_hit), 1);
    chk("t3_taken", 32'(o_pred_taken), 1);
    chk("t3_target", o_pred_target, 32'h80);
    br(32'h100, 1, 32'h80, 1, 32'h80); step();
    br(32'h100, 0, 32'h80, 1, 32'h80); step();
    br(32'h100, 0, 32'h80, 1, 32'h80); step();
    look(32'h100);
    chk("t3_nt", 32'(o_pred_taken), 0);
    br(32'h100, 0, 32'h80, 0, 0); step();
    br(32'h100, 1, 32'h80, 0, 0); step();
    look(32'h100);
    chk("t3_floor", 32'(o_pred_taken), 0);
    br(32'h100, 1, 32'h80, 0, 0); step();
    look(32'h100);
    chk("t3_recover", 32'(o_pred_taken), 1);
    // Alias on index 0.
    br(32'h200, 1, 32'h40, 0, 0); step();
    look(32'h100);
    chk("t4_old_miss", 32'(o_pred_hit), 0);
    look(32'h200);
    chk("t4_new_hit", 32'(o_pred_hit), 1);
    chk("t4_new_target", o_pred_target, 32'h40);
    i_if_pc = 32'h0; br(32'h300, 1, 32'h84, 1, 32'h80); #2;
    chk("t5_target_diff", 32'(o_ex_mispredict), 1);
    step();
    br(32'h300, 1, 32'h80, 1, 32'h80); #2;
    chk("t5_target_same", 32'(o_ex_mispredict), 0);
    step();
    i_if_pc = 32'h100; br(32'h100, 1, 32'h90, 0, 0); #2;
    chk("t6_old", 32'(o_pred_hit), 0);
    step();
    look(32'h100);
    chk("t6_new_hit", 32'(o_pred_hit), 1);
    chk("t6_new_target", o_pred_target, 32'h90);
    i_if_pc = 32'h100; i_ex_vld = 1; i_ex_is_br = 0; i_ex_pc = 32'h100;
    i_ex_taken = 0; i_ex_pred_taken = 1; step();
    look(32'h100);
    chk("nonbr_untouched", 32'(o_pred_taken), 1);
    for (int k = 0; k < 400; k++) begin
      logic [31:0] tg;
      i_if_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      i_ex_vld = 1'($urandom); i_ex_is_br = ($urandom_range(0, 3) != 0);
      i_ex_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      i_ex_taken = 1'($urandom); tg = $urandom & 32'hfffc;
      i_ex_target = tg; i_ex_pred_taken = 1'($urandom);
      i_ex_pred_target = $urandom_range(0, 1) ? tg : tg + 4;
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
